// File: rtl/regfile_param_if.sv
// Register-file bus: operand read ports, writeback, reservation and debug read.
// Every output is registered by the register file, so the master may drive
// inputs at any time. The file accepts a write or a reservation on every
// cycle without back-pressure, and it returns data one clock edge after the
// address is presented.
interface regfile_param_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
);

  // Operand read ports; port k occupies slice k of each flattened vector.
  logic [NUM_READ*ADDR_WIDTH-1:0] read_address;
  logic [NUM_READ*DATA_WIDTH-1:0] data_out;
  logic [NUM_READ-1:0]            read_pending;

  // Writeback from the end of the pipeline.
  logic                           write_enable;
  logic [ADDR_WIDTH-1:0]          write_address;
  logic [DATA_WIDTH-1:0]          write_data_in;

  // Issue-time reservation of a destination register.
  logic                           reserve_enable;
  logic [ADDR_WIDTH-1:0]          reserve_address;

  // Debug read port, synchronous to the main clock.
  logic [ADDR_WIDTH-1:0]          read_address_debug;
  logic [DATA_WIDTH-1:0]          data_out_debug;

  // Number of registers that currently have an outstanding producer.
  logic [ADDR_WIDTH:0]            busy_count;

  // Pipeline side: issues reads, writebacks and reservations.
  modport master (
    output read_address,
    output write_enable,
    output write_address,
    output write_data_in,
    output reserve_enable,
    output reserve_address,
    output read_address_debug,
    input  data_out,
    input  read_pending,
    input  data_out_debug,
    input  busy_count
  );

  // Register-file side.
  modport slave (
    input  read_address,
    input  write_enable,
    input  write_address,
    input  write_data_in,
    input  reserve_enable,
    input  reserve_address,
    input  read_address_debug,
    output data_out,
    output read_pending,
    output data_out_debug,
    output busy_count
  );

endinterface

// File: rtl/regfile_param.sv
// Parametrised register file with write-first registered reads, an optional
// hardwired-zero register and a per-register pending (busy) scoreboard.
// The next-state values of the storage and the busy bits are computed first.
// Every read port then samples those post-update values, which gives the
// write-first bypass and the reserve-over-clear priority without a separate
// forwarding path.
module regfile_param #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int NUM_READ    = 2,
  parameter bit ZERO_REG    = 1'b1,
  parameter bit RESET_INDEX = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  regfile_param_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  // Architectural state.
  word_t                  regs_q [DEPTH];
  word_t                  regs_d [DEPTH];
  logic [DEPTH-1:0]       busy_q;
  logic [DEPTH-1:0]       busy_d;

  // Next values of the registered outputs.
  logic [NUM_READ*DATA_WIDTH-1:0] data_d;
  logic [NUM_READ-1:0]            pending_d;
  word_t                          debug_d;
  logic [CW-1:0]                  count_d;

  // Qualified strobes: with the zero register enabled, a write or a
  // reservation that targets register 0 is dropped.
  logic write_ok;
  logic reserve_ok;

  assign write_ok   = bus.write_enable &&
                      !(ZERO_REG && (bus.write_address == addr_t'(0)));
  assign reserve_ok = bus.reserve_enable &&
                      !(ZERO_REG && (bus.reserve_address == addr_t'(0)));

  // Reset contents of register idx. The index is truncated to the data width.
  function automatic word_t reset_value(input int idx);
    if (RESET_INDEX) begin
      return word_t'(idx);
    end
    return '0;
  endfunction

  // True when addr names the hardwired-zero register.
  function automatic logic is_zero_reg(input addr_t addr);
    return ZERO_REG && (addr == addr_t'(0));
  endfunction

  // Post-update storage and busy bits. The write is applied first (data, and
  // the producer finished), then the reservation, so a same-cycle reserve of
  // the written register leaves it busy for the newly issued producer.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (write_ok) begin
      regs_d[bus.write_address] = bus.write_data_in;
      busy_d[bus.write_address] = 1'b0;
    end
    if (reserve_ok) begin
      busy_d[bus.reserve_address] = 1'b1;
    end
  end

  // Operand and debug read data, taken from the post-update state. Register 0
  // is forced to zero / not pending so stored contents can never leak out.
  always_comb begin
    data_d    = '0;
    pending_d = '0;
    debug_d   = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      if (!is_zero_reg(bus.read_address[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
        data_d[k*DATA_WIDTH +: DATA_WIDTH] =
          regs_d[bus.read_address[k*ADDR_WIDTH +: ADDR_WIDTH]];
        pending_d[k] = busy_d[bus.read_address[k*ADDR_WIDTH +: ADDR_WIDTH]];
      end
    end
    if (!is_zero_reg(bus.read_address_debug)) begin
      debug_d = regs_d[bus.read_address_debug];
    end
  end

  // Population count of the post-update busy bits. The width is one bit wider
  // than the address, so the count reaches the full depth without wrapping.
  always_comb begin
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + CW'(busy_d[i]);
    end
  end

  // Storage update. Reset dominates, so a write issued in a reset cycle
  // is discarded.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= reset_value(i);
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Busy scoreboard update. Reset dominates, so a reservation issued in a
  // reset cycle is discarded.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Registered read outputs. No input reaches an output combinationally.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.data_out       <= '0;
      bus.read_pending   <= '0;
      bus.data_out_debug <= '0;
      bus.busy_count     <= '0;
    end else begin
      bus.data_out       <= data_d;
      bus.read_pending   <= pending_d;
      bus.data_out_debug <= debug_d;
      bus.busy_count     <= count_d;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Testbench for regfile_param: directed scenarios plus randomized traffic
// checked against an array-based reference model of the register file.
// A second instance covers the narrow, four-port, zero-reset configuration.
module tb_regfile_param;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2)) bus ();
  regfile_param #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(1'b1), .RESET_INDEX(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  regfile_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_READ(4)) bus8 ();
  regfile_param #(
    .DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_READ(4), .ZERO_REG(1'b1), .RESET_INDEX(1'b0)
  ) dut8 (
    .clock(clock),
    .reset(reset),
    .bus  (bus8)
  );

  // ---------------- reference model (main instance) ----------------
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  logic [31:0] e_data [2];
  bit          e_pend [2];
  logic [31:0] e_dbg;
  int          e_cnt;

  // Register value as seen by a reader: register 0 is always zero.
  function automatic logic [31:0] m_read(input int a);
    return (a == 0) ? 32'h0 : m_regs[a];
  endfunction

  // Apply this cycle's inputs to the model, then advance one clock and move
  // to the falling edge, where outputs are sampled and new inputs are driven.
  task automatic step();
    int a;
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = i;
        m_busy[i] = 0;
      end
      e_data[0] = 0; e_data[1] = 0;
      e_pend[0] = 0; e_pend[1] = 0;
      e_dbg = 0;
      e_cnt = 0;
    end else begin
      if (bus.write_enable && bus.write_address != 0) begin
        m_regs[bus.write_address] = bus.write_data_in;
        m_busy[bus.write_address] = 0;
      end
      if (bus.reserve_enable && bus.reserve_address != 0) begin
        m_busy[bus.reserve_address] = 1;
      end
      for (int k = 0; k < 2; k++) begin
        a = int'(bus.read_address[k*5 +: 5]);
        e_data[k] = m_read(a);
        e_pend[k] = (a == 0) ? 1'b0 : m_busy[a];
      end
      e_dbg = m_read(int'(bus.read_address_debug));
      e_cnt = 0;
      for (int i = 0; i < 32; i++) e_cnt += int'(m_busy[i]);
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.write_enable   = 1'b0;
    bus.reserve_enable = 1'b0;
  endtask

  task automatic drive_reads(input int a0, input int a1, input int ad);
    bus.read_address[4:0] = 5'(a0);
    bus.read_address[9:5] = 5'(a1);
    bus.read_address_debug = 5'(ad);
  endtask

  task automatic drive_write(input int a, input logic [31:0] d);
    bus.write_enable  = 1'b1;
    bus.write_address = 5'(a);
    bus.write_data_in = d;
  endtask

  task automatic drive_reserve(input int a);
    bus.reserve_enable  = 1'b1;
    bus.reserve_address = 5'(a);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    drive_reads(0, 0, 0);
    step();
    n_checks++;
    if (bus.data_out !== 64'h0) begin
      n_fail++; $display("FAIL reset_data_out: got %h expected 0", bus.data_out);
    end
    n_checks++;
    if (bus.read_pending !== 2'b00 || bus.busy_count !== 6'd0) begin
      n_fail++; $display("FAIL reset_pending_count: got %b/%0d expected 0/0", bus.read_pending, bus.busy_count);
    end
    n_checks++;
    if (bus.data_out_debug !== 32'h0) begin
      n_fail++; $display("FAIL reset_debug: got %h expected 0", bus.data_out_debug);
    end
  endtask

  task automatic test_reset_read();
    reset = 1'b0;
    drive_reads(3, 31, 17);
    step();
    n_checks++;
    if (bus.data_out[31:0] !== 32'd3 || bus.data_out[63:32] !== 32'd31) begin
      n_fail++; $display("FAIL reset_read_data: got %h expected %h", bus.data_out, {32'd31, 32'd3});
    end
    n_checks++;
    if (bus.read_pending !== 2'b00 || bus.busy_count !== 6'd0) begin
      n_fail++; $display("FAIL reset_read_pending: got %b/%0d expected 00/0", bus.read_pending, bus.busy_count);
    end
    n_checks++;
    if (bus.data_out_debug !== 32'd17) begin
      n_fail++; $display("FAIL reset_read_debug: got %h expected %h", bus.data_out_debug, 32'd17);
    end
  endtask

  task automatic test_bypass();
    drive_write(7, 32'hDEADBEEF);
    drive_reads(7, 8, 7);
    step();
    n_checks++;
    if (bus.data_out[31:0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL bypass_same_cycle: got %h expected deadbeef", bus.data_out[31:0]);
    end
    n_checks++;
    if (bus.data_out[63:32] !== 32'd8 || bus.data_out_debug !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL bypass_other_ports: got %h/%h expected 8/deadbeef", bus.data_out[63:32], bus.data_out_debug);
    end
    drive_idle();
    step();
    n_checks++;
    if (bus.data_out[31:0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL bypass_next_cycle: got %h expected deadbeef", bus.data_out[31:0]);
    end
  endtask

  task automatic test_zero_reg();
    drive_reserve(12);
    step();
    drive_idle();
    drive_write(0, 32'h1234);
    drive_reserve(0);
    drive_reads(0, 0, 0);
    step();
    n_checks++;
    if (bus.data_out !== 64'h0 || bus.data_out_debug !== 32'h0) begin
      n_fail++; $display("FAIL zero_reg_data: got %h/%h expected 0", bus.data_out, bus.data_out_debug);
    end
    n_checks++;
    if (bus.read_pending !== 2'b00 || bus.busy_count !== 6'd1) begin
      n_fail++; $display("FAIL zero_reg_pending: got %b/%0d expected 00/1", bus.read_pending, bus.busy_count);
    end
    drive_idle();
    step();
    n_checks++;
    if (bus.data_out !== 64'h0) begin
      n_fail++; $display("FAIL zero_reg_stored: got %h expected 0", bus.data_out);
    end
    // Retire the reg 12 producer so the scoreboard scenario starts empty.
    drive_write(12, 32'hC);
    step();
    drive_idle();
  endtask

  task automatic test_scoreboard();
    drive_reserve(5);
    drive_reads(5, 6, 5);
    step();
    n_checks++;
    if (bus.busy_count !== 6'd1 || bus.read_pending !== 2'b01) begin
      n_fail++; $display("FAIL sb_reserve: got %0d/%b expected 1/01", bus.busy_count, bus.read_pending);
    end
    n_checks++;
    if (bus.data_out[31:0] !== 32'd5) begin
      n_fail++; $display("FAIL sb_reserve_data: got %h expected 5", bus.data_out[31:0]);
    end
    drive_idle();
    drive_write(5, 32'h55);
    step();
    n_checks++;
    if (bus.data_out[31:0] !== 32'h55 || bus.read_pending[0] !== 1'b0) begin
      n_fail++; $display("FAIL sb_writeback: got %h/%b expected 55/0", bus.data_out[31:0], bus.read_pending[0]);
    end
    n_checks++;
    if (bus.busy_count !== 6'd0) begin
      n_fail++; $display("FAIL sb_count_clear: got %0d expected 0", bus.busy_count);
    end
    drive_idle();
  endtask

  task automatic test_write_reserve();
    drive_write(9, 32'hA);
    drive_reserve(9);
    drive_reads(9, 9, 9);
    step();
    n_checks++;
    if (bus.data_out !== {32'hA, 32'hA} || bus.data_out_debug !== 32'hA) begin
      n_fail++; $display("FAIL wr_res_data: got %h/%h expected a", bus.data_out, bus.data_out_debug);
    end
    n_checks++;
    if (bus.read_pending !== 2'b11 || bus.busy_count !== 6'd1) begin
      n_fail++; $display("FAIL wr_res_pending: got %b/%0d expected 11/1", bus.read_pending, bus.busy_count);
    end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    drive_write(2, 32'hFF);
    step();
    drive_idle();
    for (int r = 1; r <= 4; r++) begin
      drive_reserve(r);
      step();
    end
    drive_idle();
    drive_reads(2, 3, 2);
    step();
    n_checks++;
    if (bus.busy_count !== 6'(e_cnt) || bus.data_out[31:0] !== 32'hFF) begin
      n_fail++; $display("FAIL mid_before_reset: got %0d/%h expected %0d/ff", bus.busy_count, bus.data_out[31:0], e_cnt);
    end
    reset = 1'b1;
    drive_write(3, 32'h77);
    drive_reserve(6);
    step();
    n_checks++;
    if (bus.data_out !== 64'h0 || bus.read_pending !== 2'b00 ||
        bus.data_out_debug !== 32'h0 || bus.busy_count !== 6'd0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %h/%b/%h/%0d expected all 0",
                         bus.data_out, bus.read_pending, bus.data_out_debug, bus.busy_count);
    end
    reset = 1'b0;
    drive_idle();
    drive_reads(2, 3, 6);
    step();
    n_checks++;
    if (bus.data_out[31:0] !== 32'd2 || bus.data_out[63:32] !== 32'd3 || bus.data_out_debug !== 32'd6) begin
      n_fail++; $display("FAIL mid_after_reset: got %h/%h expected %h/6", bus.data_out, bus.data_out_debug, {32'd3, 32'd2});
    end
    n_checks++;
    if (bus.read_pending !== 2'b00 || bus.busy_count !== 6'd0) begin
      n_fail++; $display("FAIL mid_after_busy: got %b/%0d expected 00/0", bus.read_pending, bus.busy_count);
    end
  endtask

  task automatic test_random();
    int a0, a1, wa;
    for (int c = 0; c < 400; c++) begin
      drive_idle();
      wa = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 31);
      if ($urandom_range(0, 2) != 0) drive_write(wa, $urandom);
      if ($urandom_range(0, 2) != 0)
        drive_reserve(($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31));
      a0 = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 31);
      a1 = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 7);
      drive_reads(a0, a1, $urandom_range(0, 31));
      step();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (bus.data_out[k*32 +: 32] !== e_data[k] || bus.read_pending[k] !== e_pend[k]) begin
          n_fail++; $display("FAIL rand_port%0d cycle %0d: got %h/%b expected %h/%b",
                             k, c, bus.data_out[k*32 +: 32], bus.read_pending[k], e_data[k], e_pend[k]);
        end
      end
      n_checks++;
      if (bus.data_out_debug !== e_dbg || bus.busy_count !== 6'(e_cnt)) begin
        n_fail++; $display("FAIL rand_debug_count cycle %0d: got %h/%0d expected %h/%0d",
                           c, bus.data_out_debug, bus.busy_count, e_dbg, e_cnt);
      end
    end
    drive_idle();
  endtask

  task automatic test_sweep();
    logic [7:0] m8 [8];
    logic [7:0] base;
    logic [7:0] exp_v;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) m8[i] = 8'h0;
    for (int round = 0; round < 2; round++) begin
      for (int k = 0; k < 4; k++) bus8.read_address[k*3 +: 3] = 3'(round*4 + k);
      step();
      n_checks++;
      if (bus8.data_out !== 32'h0 || bus8.read_pending !== 4'h0 || bus8.busy_count !== 4'd0) begin
        n_fail++; $display("FAIL sweep_reset_round%0d: got %h/%b/%0d expected 0", round, bus8.data_out, bus8.read_pending, bus8.busy_count);
      end
    end
    base = 8'($urandom);
    for (int i = 0; i < 8; i++) begin
      bus8.write_enable  = 1'b1;
      bus8.write_address = 3'(i);
      bus8.write_data_in = base + 8'(i * 29);
      if (i != 0) m8[i] = base + 8'(i * 29);
      step();
    end
    bus8.write_enable = 1'b0;
    for (int round = 0; round < 2; round++) begin
      for (int k = 0; k < 4; k++) bus8.read_address[k*3 +: 3] = 3'((round*4 + k + 1) % 8);
      step();
      for (int k = 0; k < 4; k++) begin
        exp_v = m8[(round*4 + k + 1) % 8];
        n_checks++;
        if (bus8.data_out[k*8 +: 8] !== exp_v) begin
          n_fail++; $display("FAIL sweep_read r%0d p%0d: got %h expected %h", round, k, bus8.data_out[k*8 +: 8], exp_v);
        end
      end
    end
    bus8.reserve_enable  = 1'b1;
    bus8.reserve_address = 3'd7;
    bus8.read_address    = {3'd7, 3'd6, 3'd7, 3'd0};
    step();
    bus8.reserve_enable = 1'b0;
    n_checks++;
    if (bus8.busy_count !== 4'd1 || bus8.read_pending !== 4'b1010) begin
      n_fail++; $display("FAIL sweep_reserve: got %0d/%b expected 1/1010", bus8.busy_count, bus8.read_pending);
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    reset = 1'b1;
    bus.read_address = '0;
    bus.write_enable = 1'b0;
    bus.write_address = '0;
    bus.write_data_in = '0;
    bus.reserve_enable = 1'b0;
    bus.reserve_address = '0;
    bus.read_address_debug = '0;
    bus8.read_address = '0;
    bus8.write_enable = 1'b0;
    bus8.write_address = '0;
    bus8.write_data_in = '0;
    bus8.reserve_enable = 1'b0;
    bus8.reserve_address = '0;
    bus8.read_address_debug = '0;

    test_reset();
    test_reset_read();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_write_reserve();
    test_reset_mid();
    test_random();
    test_sweep();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised register file, the next generation of the processor's register storage. It adds configurable data width, depth and read-port count, and a hardwired-zero register option. It also adds write-first bypass on registered reads and a per-register pending scoreboard for load/multi-cycle hazard tracking. It sits in the decode stage of the pipeline, feeding operands to execute and receiving writeback results. Its debug port is now synchronous to the main clock.

## Interface

- DATA_WIDTH, 32, width of each register
- ADDR_WIDTH, 5, address width; depth is 2**ADDR_WIDTH
- NUM_READ, 2, number of operand read ports (1..4)
- ZERO_REG, 1, when 1, register 0 reads as 0 and ignores writes and reservations
- RESET_INDEX, 1, when 1, register i resets to i (truncated to DATA_WIDTH); when 0, all registers reset to 0

Ports:

- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- read_address  in  NUM_READ*ADDR_WIDTH  port k address at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- data_out  out  NUM_READ*DATA_WIDTH  port k registered read data
- read_pending  out  NUM_READ  port k registered busy flag of addressed register
- write_enable  in  1  writeback strobe
- write_address  in  ADDR_WIDTH  writeback target
- write_data_in  in  DATA_WIDTH  writeback data
- reserve_enable  in  1  mark a register as having an outstanding producer
- reserve_address  in  ADDR_WIDTH  register to reserve
- read_address_debug  in  ADDR_WIDTH  debug read address
- data_out_debug  out  DATA_WIDTH  registered debug read data
- busy_count  out  ADDR_WIDTH+1  number of registers currently pending

## Operation

- Storage: 2**ADDR_WIDTH registers of DATA_WIDTH, plus 2**ADDR_WIDTH busy bits.
- Write: when write_enable=1, registers[write_address] <= write_data_in. If ZERO_REG=1 and the address is 0, the write is dropped.
- Write also clears busy[write_address].
- Reserve: when reserve_enable=1, busy[reserve_address] <= 1. If ZERO_REG=1 and the address is 0, the reservation is ignored.
- Write and reserve to the same address in the same cycle:
  - the data is written;
  - busy ends at 1, because reserve wins (a new producer has issued).
- Read, every cycle, for each port k and for the debug port:
  - data_out_k <= post-update value of the addressed register;
  - read_pending_k <= post-update busy of the addressed register.
- Write-first bypass: a read that hits the same-cycle write address returns write_data_in, and its pending flag reflects the clear and reserve rules above.
- ZERO_REG=1 and read address 0: data_out = 0 and pending = 0 regardless of stored state.
- busy_count <= popcount of post-update busy bits.
- All read ports are independent. Any ports may address the same register; each returns identical data.

## Timing

- Read latency is 1 cycle: the address is presented in cycle N and data/pending are valid after the rising edge ending cycle N.
- Write is visible on a read port in the same cycle through bypass. A write in cycle N and a read of the same address in cycle N return the new data after that edge.
- Reset (synchronous, dominates all other inputs in that cycle):
  - registers[i] <= (RESET_INDEX ? i : 0), with register 0 = 0;
  - all busy bits <= 0;
  - data_out, read_pending, data_out_debug <= 0;
  - busy_count <= 0.
- A write_enable or reserve_enable asserted in a reset cycle is discarded.
- The first post-reset read returns the reset value after one edge.
- busy_count range is 0..2**ADDR_WIDTH (or 2**ADDR_WIDTH-1 with ZERO_REG=1). It never wraps, because its width is ADDR_WIDTH+1.
- No combinational path from any input to any output.

## Test plan

- Reset then read: reset 1 cycle, then read ports on addresses 3 and 31 -> data_out 3 and 31 after one edge, pending 0, busy_count 0.
- Write-first bypass: write 0xDEADBEEF to reg 7 while port 0 reads 7 -> data_out_0 = 0xDEADBEEF after the same edge. A read of 7 on the next cycle still returns 0xDEADBEEF.
- Zero register: write 0x1234 to reg 0 and reserve reg 0 -> reading reg 0 on all ports returns 0 with pending 0, and busy_count is unchanged.
- Scoreboard: reserve reg 5 -> busy_count 1 and read_pending on reg 5 is 1.
  - Next cycle, write reg 5 = 0x55 while reading it -> data 0x55, pending 0, busy_count 0.
- Simultaneous write and reserve on reg 9 with data 0xA -> data 0xA, pending stays 1, busy_count 1.
- Reset mid-operation: reserve regs 1..4 and write reg 2 = 0xFF, then assert reset together with write reg 3 = 0x77 -> all busy cleared, reg 2 = 2, reg 3 = 3, outputs 0 in the reset cycle.
- Parameter sweep: DATA_WIDTH=8, ADDR_WIDTH=3, NUM_READ=4, RESET_INDEX=0 -> all 8 regs reset to 0, and 4 ports read distinct written values correctly.
